score_logger: RTL and testbench
===============================

SCORE_LOGGER -- requirements
Module: score_logger

Interface
REQ-001 Parameter SCORE_W, default 10, score width in bits.
REQ-002 Parameter ADDR_W, default 5, score-memory address width; DEPTH = 2**ADDR_W (32).
REQ-003 Port clock, input, 1, sole clock, all logic on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port game_over, input, 1, single-cycle pulse; the game has ended and score is valid.
REQ-006 Port score, input, SCORE_W, final score of the game; sampled only with game_over.
REQ-007 Port clear_req, input, 1, single-cycle pulse requesting that all DEPTH entries be zeroed.
REQ-008 Port address, output, ADDR_W, write address to the score memory.
REQ-009 Port data, output, SCORE_W, write data to the score memory.
REQ-010 Port wren, output, 1, write strobe to the score memory.
REQ-011 Port busy, output, 1, high while in WRITE or CLEAR.
REQ-012 Port entries, output, ADDR_W+1, count of valid scores written since the last clear, saturating at DEPTH.
REQ-013 Port overrun, output, 1, sticky flag; a game_over or clear_req arrived while busy.

Function
REQ-014 The FSM SHALL have states IDLE, WRITE and CLEAR; all outputs SHALL be registered.
REQ-015 In IDLE, game_over=1 at edge N SHALL capture score into data and the write pointer into address, and enter WRITE; wren=1 and busy=1 during cycle N+1.
REQ-016 WRITE SHALL last exactly one cycle, then return to IDLE with wren=0; the write pointer SHALL increment modulo DEPTH (31 wraps to 0).
REQ-017 On each completed write, entries SHALL increment, saturating at DEPTH (32); wrap-around SHALL overwrite the oldest slot.
REQ-018 A score of 0 SHALL still be written and counted.
REQ-019 In IDLE, clear_req=1 SHALL enter CLEAR; CLEAR SHALL drive data=0, wren=1 and address=0,1,...,DEPTH-1 on DEPTH consecutive cycles, then return to IDLE.
REQ-020 On leaving CLEAR, the write pointer, entries and overrun SHALL be 0.
REQ-021 When game_over and clear_req are both high in IDLE, game_over SHALL win; clear_req SHALL be latched as pending and CLEAR SHALL begin on the cycle after WRITE ends.
REQ-022 game_over received in WRITE or CLEAR SHALL be discarded, with no write, and SHALL set overrun.
REQ-023 clear_req received in WRITE SHALL be latched as pending per REQ-021; clear_req received in CLEAR SHALL be ignored and SHALL set overrun.
REQ-024 wren SHALL never be high in IDLE; address and data SHALL hold their last values in IDLE.

Reset
REQ-025 reset=1 SHALL force state IDLE, address=0, data=0, wren=0, busy=0, entries=0, overrun=0, write pointer=0 and pending clear=0 on the next edge.
REQ-026 reset SHALL take priority over every other input.
REQ-027 reset asserted mid-CLEAR or mid-WRITE SHALL abort the operation with no further wren.

Structure
REQ-028 SCORE_W, ADDR_W, DEPTH and the state enum (IDLE, WRITE, CLEAR) SHALL live in a shared package, score_pkg.
REQ-029 The block SHALL be a single module with no sub-modules.
REQ-030 Its address, data and wren outputs SHALL connect directly to the score-memory write port.

Verification
REQ-031 Scenario, single write: reset, then game_over with score=10'd517 -> next cycle wren=1, address=0, data=517; following cycle wren=0; entries=1.
REQ-032 Scenario, wrap: 33 games with scores 1..33 -> the 33rd write goes to address 0 with data=33; entries stays at 32.
REQ-033 Scenario, clear: after 5 writes, pulse clear_req -> 32 cycles of wren=1 with data=0 and address 0..31, busy high throughout; then entries=0, and the next game_over writes address 0.
REQ-034 Scenario, collision: game_over (score=200) and clear_req in the same cycle -> write of 200 at the current pointer, then CLEAR starting the following cycle; overrun=0.
REQ-035 Scenario, overrun: game_over during CLEAR cycle 10 -> no extra write, overrun=1; overrun=0 after CLEAR completes.
REQ-036 Scenario, reset mid-CLEAR: assert reset at CLEAR cycle 15 -> wren=0 from the next cycle, busy=0, entries=0, address=0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared widths and FSM state encoding for the score logger.
package score_pkg;

    localparam int SCORE_W = 10;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/score_logger.sv
// Logs final game scores into a circular score memory and can wipe the whole
// memory on request; every output comes straight from a flop.
module score_logger
    import score_pkg::state_t, score_pkg::IDLE, score_pkg::WRITE, score_pkg::CLEAR;
#(
    parameter int SCORE_W = score_pkg::SCORE_W,
    parameter int ADDR_W  = score_pkg::ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               game_over,
    input  logic [SCORE_W-1:0] score,
    input  logic               clear_req,
    output logic [ADDR_W-1:0]  address,
    output logic [SCORE_W-1:0] data,
    output logic               wren,
    output logic               busy,
    output logic [ADDR_W:0]    entries,
    output logic               overrun
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ENTRIES_MAX = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic                pend_clear, pend_clear_nxt;
    logic [ADDR_W-1:0]   address_nxt;
    logic [SCORE_W-1:0]  data_nxt;
    logic                wren_nxt, busy_nxt, overrun_nxt;
    logic [ADDR_W:0]     entries_nxt;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        pend_clear_nxt = pend_clear;
        address_nxt    = address;
        data_nxt       = data;
        wren_nxt       = 1'b0;
        busy_nxt       = 1'b0;
        entries_nxt    = entries;
        overrun_nxt    = overrun;

        case (state)
            IDLE: begin
                // A simultaneous clear loses to the game but is remembered.
                if (game_over) begin
                    state_nxt      = WRITE;
                    address_nxt    = wr_ptr;
                    data_nxt       = score;
                    wren_nxt       = 1'b1;
                    busy_nxt       = 1'b1;
                    pend_clear_nxt = pend_clear | clear_req;
                end else if (clear_req || pend_clear) begin
                    state_nxt      = CLEAR;
                    address_nxt    = '0;
                    data_nxt       = '0;
                    wren_nxt       = 1'b1;
                    busy_nxt       = 1'b1;
                    pend_clear_nxt = 1'b0;
                end
            end

            WRITE: begin
                wr_ptr_nxt = wr_ptr + ADDR_W'(1);
                if (entries != ENTRIES_MAX) begin
                    entries_nxt = entries + (ADDR_W + 1)'(1);
                end
                if (game_over) begin
                    overrun_nxt = 1'b1;
                end
                if (clear_req || pend_clear) begin
                    state_nxt      = CLEAR;
                    address_nxt    = '0;
                    data_nxt       = '0;
                    wren_nxt       = 1'b1;
                    busy_nxt       = 1'b1;
                    pend_clear_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            CLEAR: begin
                if (game_over || clear_req) begin
                    overrun_nxt = 1'b1;
                end
                // The address output doubles as the sweep counter.
                if (address == ADDR_LAST) begin
                    state_nxt      = IDLE;
                    wr_ptr_nxt     = '0;
                    entries_nxt    = '0;
                    overrun_nxt    = 1'b0;
                    pend_clear_nxt = 1'b0;
                end else begin
                    address_nxt = address + ADDR_W'(1);
                    wren_nxt    = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            pend_clear <= 1'b0;
            address    <= '0;
            data       <= '0;
            wren       <= 1'b0;
            busy       <= 1'b0;
            entries    <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            pend_clear <= pend_clear_nxt;
            address    <= address_nxt;
            data       <= data_nxt;
            wren       <= wren_nxt;
            busy       <= busy_nxt;
            entries    <= entries_nxt;
            overrun    <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_score_logger.sv
// Self-checking bench for score_logger: a scoreboard of expected memory writes
// checked by a write monitor, plus per-scenario inline checks.
module tb_score_logger;

    localparam int SW    = 10;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          game_over;
    logic [SW-1:0] score;
    logic          clear_req;
    logic [AW-1:0] address;
    logic [SW-1:0] data;
    logic          wren;
    logic          busy;
    logic [AW:0]   entries;
    logic          overrun;

    score_logger #(.SCORE_W(SW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .game_over (game_over),
        .score     (score),
        .clear_req (clear_req),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .busy      (busy),
        .entries   (entries),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [SW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_exp;
    int  vectors     = 0;
    int  miscompares = 0;
    int  exp_ptr     = 0;
    int  exp_entries = 0;

    // Every memory write must match the head of the scoreboard.
    always @(negedge clock) begin
        if (wren === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got address=%0d data=%0d, expected no write", address, data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (address !== mon_exp.a || data !== mon_exp.d) begin
                    miscompares++;
                    $display("FAIL write: got address=%0d data=%0d, expected address=%0d data=%0d",
                             address, data, mon_exp.a, mon_exp.d);
                end
            end
        end
    end

    task automatic push_exp(input int a, input logic [SW-1:0] d);
        wr_t w;
        w.a = AW'(a);
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) push_exp(i, '0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        game_over = 1'b0;
        clear_req = 1'b0;
        score     = '0;
        repeat (2) @(negedge clock);
        reset       = 1'b0;
        exp_q.delete();
        exp_ptr     = 0;
        exp_entries = 0;
    endtask

    // One game ending at the current negedge; returns two negedges later in IDLE.
    task automatic play(input logic [SW-1:0] s);
        game_over = 1'b1;
        score     = s;
        push_exp(exp_ptr, s);
        @(negedge clock);
        game_over = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL play_busy: got %b, expected 1", busy);
        end
        @(negedge clock);
        exp_ptr = (exp_ptr + 1) % DEPTH;
        if (exp_entries < DEPTH) exp_entries++;
        vectors++;
        if (wren !== 1'b0 || busy !== 1'b0 || entries !== (AW + 1)'(exp_entries)) begin
            miscompares++;
            $display("FAIL play_after: got wren=%b busy=%b entries=%0d, expected 0 0 %0d",
                     wren, busy, entries, exp_entries);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        game_over = 1'b1;
        clear_req = 1'b1;
        score     = 10'd999;
        repeat (3) @(negedge clock);
        vectors++;
        if (address !== '0 || data !== '0 || wren !== 1'b0 || busy !== 1'b0 ||
            entries !== '0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got address=%0d data=%0d wren=%b busy=%b entries=%0d overrun=%b, expected all 0",
                     address, data, wren, busy, entries, overrun);
        end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        play(10'd517);
        play(10'd0);
    endtask

    task automatic test_back_to_back();
        game_over = 1'b1;
        score     = 10'd300;
        push_exp(exp_ptr, 10'd300);
        @(negedge clock);
        score = 10'd55;
        @(negedge clock);
        game_over = 1'b0;
        exp_ptr   = (exp_ptr + 1) % DEPTH;
        exp_entries++;
        vectors++;
        if (overrun !== 1'b1 || wren !== 1'b0 || entries !== (AW + 1)'(exp_entries)) begin
            miscompares++;
            $display("FAIL back_to_back: got overrun=%b wren=%b entries=%0d, expected 1 0 %0d",
                     overrun, wren, entries, exp_entries);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 33; i++) play(SW'(i));
        vectors++;
        if (entries !== 6'd32) begin
            miscompares++;
            $display("FAIL wrap_entries: got %0d, expected 32", entries);
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 5; i++) play(SW'(100 + i));
        clear_req = 1'b1;
        push_clear(DEPTH);
        @(negedge clock);
        clear_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (busy !== 1'b1 || wren !== 1'b1) begin
                miscompares++;
                $display("FAIL clear_cycle%0d: got busy=%b wren=%b, expected 1 1", i, busy, wren);
            end
            @(negedge clock);
        end
        exp_ptr     = 0;
        exp_entries = 0;
        vectors++;
        if (busy !== 1'b0 || wren !== 1'b0 || entries !== '0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_done: got busy=%b wren=%b entries=%0d overrun=%b, expected 0 0 0 0",
                     busy, wren, entries, overrun);
        end
        play(10'd42);
    endtask

    task automatic test_collision();
        game_over = 1'b1;
        clear_req = 1'b1;
        score     = 10'd200;
        push_exp(exp_ptr, 10'd200);
        push_clear(DEPTH);
        @(negedge clock);
        game_over = 1'b0;
        clear_req = 1'b0;
        @(negedge clock);
        vectors++;
        if (wren !== 1'b1 || address !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_clear_start: got wren=%b address=%0d busy=%b, expected 1 0 1",
                     wren, address, busy);
        end
        repeat (DEPTH) @(negedge clock);
        exp_ptr     = 0;
        exp_entries = 0;
        vectors++;
        if (busy !== 1'b0 || overrun !== 1'b0 || entries !== '0) begin
            miscompares++;
            $display("FAIL collision_done: got busy=%b overrun=%b entries=%0d, expected 0 0 0",
                     busy, overrun, entries);
        end
    endtask

    task automatic test_overrun();
        clear_req = 1'b1;
        push_clear(DEPTH);
        @(negedge clock);
        clear_req = 1'b0;
        repeat (9) @(negedge clock);
        game_over = 1'b1;
        score     = 10'd777;
        @(negedge clock);
        game_over = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || address !== 5'd10) begin
            miscompares++;
            $display("FAIL overrun_set: got overrun=%b address=%0d, expected 1 10", overrun, address);
        end
        repeat (22) @(negedge clock);
        vectors++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_cleared: got overrun=%b busy=%b, expected 0 0", overrun, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        play(10'd5);
        clear_req = 1'b1;
        push_clear(15);
        @(negedge clock);
        clear_req = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset       = 1'b0;
        exp_ptr     = 0;
        exp_entries = 0;
        vectors++;
        if (wren !== 1'b0 || busy !== 1'b0 || entries !== '0 || address !== '0 || data !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got wren=%b busy=%b entries=%0d address=%0d data=%0d, expected all 0",
                     wren, busy, entries, address, data);
        end
        repeat (2) @(negedge clock);
        play(10'd9);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wrap();
        test_clear();
        test_collision();
        test_overrun();
        test_reset_mid_clear();
        repeat (2) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected writes never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
